// File: rtl/trng_arb_ctrl_if.sv
// trng_arb_ctrl_if
// Requester-side bus of the TRNG arbiter.
//   req    : per-requester request level, one bit per requester
//   gnt    : one-hot grant to the current owner, 0 when idle
//   rdata  : 128-bit random word for the owner
//   rvalid : rdata valid, held until rack
//   rack   : owner accepts rdata
// Handshake: rvalid is held high with rdata stable until the owner drives
// rack=1 on a clock edge; that edge completes the transfer. rack is ignored
// whenever rvalid=0.
// Modports: master = requester side, slave = arbiter side.
interface trng_arb_ctrl_if;
   logic [3:0]   req;
   logic [3:0]   gnt;
   logic [127:0] rdata;
   logic         rvalid;
   logic         rack;

   modport master (output req, output rack, input gnt, input rdata, input rvalid);
   modport slave  (input req, input rack, output gnt, output rdata, output rvalid);
endinterface

// File: rtl/trng_arb_ctrl.sv
// trng_arb_ctrl
// Round-robin arbiter that shares one TRNG core between four requesters.
// A grant restarts the core (CLEAR), runs it until trng_done or timeout
// (RUN), optionally health-checks the word (CHECK, retrying via CLEAR) and
// hands it to the owner (DELIVER).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : requester bus (req/gnt/rdata/rvalid/rack), slave modport
//   trng_rst   : one-cycle restart pulse to the TRNG core
//   trng_en    : TRNG enable, high only in RUN
//   trng_data  : TRNG output word
//   trng_done  : TRNG completion level
//   busy       : high in every state except IDLE
//   err        : one-cycle pulse on timeout or retry exhaustion
//   state_dbg  : current FSM state encoding
// Configuration: define TRNG_ARB_HEALTH_CHECK_EN to reject all-zero,
// all-ones and repeated words; otherwise CHECK always passes.
module trng_arb_ctrl #(
   parameter int TIMEOUT   = 511,
   parameter int RETRY_MAX = 3
) (
   input  logic             clk,
   input  logic             rst,
   trng_arb_ctrl_if.slave   bus,
   output logic             trng_rst,
   output logic             trng_en,
   input  logic [127:0]     trng_data,
   input  logic             trng_done,
   output logic             busy,
   output logic             err,
   output logic [2:0]       state_dbg
);

   localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
   localparam logic [RW-1:0] RETRY_MAX_C = RW'(RETRY_MAX);
   localparam logic [8:0]    TIMEOUT_C   = 9'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      CHECK   = 3'd3,
      DELIVER = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     gnt_q, gnt_d;
   logic [1:0]     own_q, own_d;
   logic [1:0]     ptr_q, ptr_d;
   logic [8:0]     cnt_q, cnt_d;
   logic [RW-1:0]  retry_q, retry_d;
   logic [127:0]   rdata_q, rdata_d;
   logic           rvalid_q, rvalid_d;
   logic           err_q, err_d;
   logic           trng_rst_q, trng_rst_d;
`ifdef TRNG_ARB_HEALTH_CHECK_EN
   logic [127:0]   hist_q, hist_d;
`endif

   logic [1:0] win, idx;
   logic       found;
   logic       owner_live;
   logic       health_ok;
   logic       rel;

   // Round-robin search starting at ptr, wrapping 3->0.
   always_comb begin
      win   = ptr_q;
      idx   = ptr_q;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!found && bus.req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   assign owner_live = |(bus.req & gnt_q);

`ifdef TRNG_ARB_HEALTH_CHECK_EN
   assign health_ok = !((rdata_q == '0) || (rdata_q == '1) || (rdata_q == hist_q));
`else
   assign health_ok = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      own_d      = own_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      retry_d    = retry_q;
      rdata_d    = rdata_q;
      rvalid_d   = rvalid_q;
      err_d      = 1'b0;
      trng_rst_d = 1'b0;
      rel        = 1'b0;
`ifdef TRNG_ARB_HEALTH_CHECK_EN
      hist_d     = hist_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req != 4'b0000) begin
               gnt_d      = 4'b0001 << win;
               own_d      = win;
               retry_d    = '0;
               cnt_d      = '0;
               trng_rst_d = 1'b1;
               state_d    = CLEAR;
            end
         end
         CLEAR: begin
            if (!owner_live) rel = 1'b1;
            else begin
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Owner drop beats everything; done beats timeout.
            if (!owner_live) rel = 1'b1;
            else if (trng_done) begin
               rdata_d = trng_data;
               state_d = CHECK;
            end else if (cnt_q == TIMEOUT_C) begin
               err_d = 1'b1;
               rel   = 1'b1;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         CHECK: begin
            if (!owner_live) rel = 1'b1;
            else if (health_ok) begin
               rvalid_d = 1'b1;
               state_d  = DELIVER;
            end else if (retry_q == RETRY_MAX_C) begin
               err_d = 1'b1;
               rel   = 1'b1;
            end else begin
               retry_d    = retry_q + RW'(1);
               cnt_d      = '0;
               trng_rst_d = 1'b1;
               state_d    = CLEAR;
            end
         end
         DELIVER: begin
            if (!owner_live) rel = 1'b1;
            else if (bus.rack) begin
               rel = 1'b1;
`ifdef TRNG_ARB_HEALTH_CHECK_EN
               hist_d = rdata_q;
`endif
            end
         end
         default: rel = 1'b1;
      endcase

      // Common release path: transaction ends, pointer moves past owner.
      if (rel) begin
         state_d  = IDLE;
         gnt_d    = 4'b0000;
         rvalid_d = 1'b0;
         ptr_d    = own_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         own_q      <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         retry_q    <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
         trng_rst_q <= 1'b1;
`ifdef TRNG_ARB_HEALTH_CHECK_EN
         hist_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         own_q      <= own_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         trng_rst_q <= trng_rst_d;
`ifdef TRNG_ARB_HEALTH_CHECK_EN
         hist_q     <= hist_d;
`endif
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign trng_rst   = trng_rst_q;
   assign trng_en    = (state_q == RUN);
   assign busy       = (state_q != IDLE);
   assign err        = err_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_trng_arb_ctrl.sv
// tb_trng_arb_ctrl
// Directed bench for trng_arb_ctrl: reset values, single transaction with
// latency, round-robin order, timeout, owner abort, reset in DELIVER and
// the health-check behaviour of the active build.
module tb_trng_arb_ctrl;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_CHECK   = 3'd3;
   localparam logic [2:0] S_DELIVER = 3'd4;

   logic         clk = 1'b0;
   logic         rst;
   logic         trng_rst, trng_en, busy, err;
   logic [127:0] trng_data;
   logic         trng_done;
   logic [2:0]   state_dbg;

   int total = 0;
   int bad   = 0;

   trng_arb_ctrl_if bus_if ();

   trng_arb_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .trng_rst  (trng_rst),
      .trng_en   (trng_en),
      .trng_data (trng_data),
      .trng_done (trng_done),
      .busy      (busy),
      .err       (err),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [3:0]   exp_gnt [5];
   logic [127:0] word;
   int           pulses;
   int           seen_rvalid;

   initial begin
      exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
      exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
      rst = 1'b1; trng_data = '0; trng_done = 1'b0;
      bus_if.req = 4'b0000; bus_if.rack = 1'b0;

      // ---------------- reset state
      tick();
      chk("rst_state", 128'(state_dbg), 128'(S_IDLE));
      chk("rst_gnt", 128'(bus_if.gnt), 128'd0);
      chk("rst_rdata", bus_if.rdata, 128'd0);
      chk("rst_rvalid", 128'(bus_if.rvalid), 128'd0);
      chk("rst_trng_rst", 128'(trng_rst), 128'd1);
      chk("rst_trng_en", 128'(trng_en), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_trng_rst", 128'(trng_rst), 128'd0);

      // ---------------- single transaction, N=201
      bus_if.req = 4'b0010;
      tick();                                   // grant edge G
      chk("t1_gnt", 128'(bus_if.gnt), 128'(4'b0010));
      chk("t1_clear", 128'(state_dbg), 128'(S_CLEAR));
      chk("t1_clear_rst", 128'(trng_rst), 128'd1);
      tick();                                   // G+1: RUN
      chk("t1_run", 128'(state_dbg), 128'(S_RUN));
      chk("t1_en", 128'(trng_en), 128'd1);
      chk("t1_rst_low", 128'(trng_rst), 128'd0);
      tick(100);                                // G+101
      bus_if.rack = 1'b1;                       // rack while rvalid=0
      bus_if.req  = 4'b1011;                    // non-owner bits change
      tick();                                   // G+102
      bus_if.rack = 1'b0;
      chk("t1_rack_ignored", 128'(state_dbg), 128'(S_RUN));
      chk("t1_nonowner_gnt", 128'(bus_if.gnt), 128'(4'b0010));
      bus_if.req = 4'b0010;
      tick(100);                                // G+202
      trng_data = 128'h3dd16a0a3554db070e0b00ce143b7344;
      trng_done = 1'b1;
      tick();                                   // G+203: CHECK
      trng_done = 1'b0;
      chk("t1_check", 128'(state_dbg), 128'(S_CHECK));
      chk("t1_rvalid_early", 128'(bus_if.rvalid), 128'd0);
      tick();                                   // G+204
      chk("t1_rvalid", 128'(bus_if.rvalid), 128'd1);
      chk("t1_rdata", bus_if.rdata, 128'h3dd16a0a3554db070e0b00ce143b7344);
      bus_if.rack = 1'b1;
      tick();
      bus_if.rack = 1'b0;
      bus_if.req  = 4'b0000;
      chk("t1_ack_gnt", 128'(bus_if.gnt), 128'd0);
      chk("t1_ack_rvalid", 128'(bus_if.rvalid), 128'd0);
      chk("t1_ack_idle", 128'(state_dbg), 128'(S_IDLE));
      chk("t1_ack_err", 128'(err), 128'd0);

      // ---------------- round robin, all requesting, ptr from reset
      rst = 1'b1; tick(); rst = 1'b0;
      bus_if.req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         tick();
         chk($sformatf("rr_gnt_%0d", t), 128'(bus_if.gnt), 128'(exp_gnt[t]));
         tick();                                // RUN
         word = {32'h1234_5678 + 32'(t), 32'hcafe_0000, 32'h0f0f_1111, 32'(t + 1)};
         trng_data = word;
         trng_done = 1'b1;
         tick();                                // CHECK
         trng_done = 1'b0;
         tick();                                // DELIVER
         chk($sformatf("rr_rdata_%0d", t), bus_if.rdata, word);
         bus_if.rack = 1'b1;
         tick();
         bus_if.rack = 1'b0;
         chk($sformatf("rr_rel_%0d", t), 128'(bus_if.gnt), 128'd0);
      end
      bus_if.req = 4'b0000;

      // ---------------- timeout (ptr=1, requester 2)
      bus_if.req = 4'b0100;
      tick();
      chk("to_gnt", 128'(bus_if.gnt), 128'(4'b0100));
      tick();                                   // RUN, count 0
      tick(511);                                // count 511
      chk("to_run_511", 128'(state_dbg), 128'(S_RUN));
      chk("to_no_err_yet", 128'(err), 128'd0);
      bus_if.req = 4'b0000;
      bus_if.req = 4'b0100;
      tick();
      bus_if.req = 4'b0000;
      chk("to_err", 128'(err), 128'd1);
      chk("to_gnt0", 128'(bus_if.gnt), 128'd0);
      chk("to_idle", 128'(state_dbg), 128'(S_IDLE));
      chk("to_en0", 128'(trng_en), 128'd0);
      tick();
      chk("to_err_pulse", 128'(err), 128'd0);

      // ---------------- owner drops in RUN (ptr=3 -> winner 0)
      bus_if.req = 4'b0001;
      tick();
      chk("ab_gnt", 128'(bus_if.gnt), 128'(4'b0001));
      tick(3);
      chk("ab_run", 128'(state_dbg), 128'(S_RUN));
      bus_if.req = 4'b0000;
      tick();
      chk("ab_gnt0", 128'(bus_if.gnt), 128'd0);
      chk("ab_en0", 128'(trng_en), 128'd0);
      chk("ab_err0", 128'(err), 128'd0);
      chk("ab_idle", 128'(state_dbg), 128'(S_IDLE));

      // ---------------- ptr advanced to 1: req 1001 -> requester 3
      bus_if.req = 4'b1001;
      tick();
      chk("ab_next_gnt", 128'(bus_if.gnt), 128'(4'b1000));
      tick();
      trng_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      trng_done = 1'b1;
      tick();
      trng_done = 1'b0;
      tick();
      chk("rd_rvalid", 128'(bus_if.rvalid), 128'd1);
      rst = 1'b1;                               // reset while in DELIVER
      tick();
      rst = 1'b0;
      bus_if.req = 4'b0000;
      chk("rd_rvalid0", 128'(bus_if.rvalid), 128'd0);
      chk("rd_rdata0", bus_if.rdata, 128'd0);
      chk("rd_gnt0", 128'(bus_if.gnt), 128'd0);
      chk("rd_err0", 128'(err), 128'd0);
      tick();

      // ---------------- all-zero word
      bus_if.req = 4'b0010;
      trng_data  = '0;
`ifdef TRNG_ARB_HEALTH_CHECK_EN
      tick();                                   // G: CLEAR
      trng_done   = 1'b1;
      pulses      = 0;
      seen_rvalid = 0;
      for (int c = 1; c <= 11; c++) begin
         tick();
         if (trng_rst) pulses++;
         if (bus_if.rvalid) seen_rvalid++;
      end
      chk("hc_retry_pulses", 128'(pulses), 128'd3);
      chk("hc_no_rvalid", 128'(seen_rvalid), 128'd0);
      chk("hc_check", 128'(state_dbg), 128'(S_CHECK));
      tick();                                   // G+12
      trng_done  = 1'b0;
      bus_if.req = 4'b0000;
      chk("hc_err", 128'(err), 128'd1);
      chk("hc_gnt0", 128'(bus_if.gnt), 128'd0);
      chk("hc_rvalid0", 128'(bus_if.rvalid), 128'd0);
`else
      tick();
      chk("hc_gnt", 128'(bus_if.gnt), 128'(4'b0010));
      tick();
      trng_done = 1'b1;
      tick();
      trng_done = 1'b0;
      tick();
      chk("hc_rvalid", 128'(bus_if.rvalid), 128'd1);
      chk("hc_rdata0", bus_if.rdata, 128'd0);
      chk("hc_no_err", 128'(err), 128'd0);
      bus_if.rack = 1'b1;
      tick();
      bus_if.rack = 1'b0;
      bus_if.req  = 4'b0000;
      chk("hc_rel", 128'(bus_if.gnt), 128'd0);
`endif
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trng_arb_ctrl.md
TRNG_ARB_CTRL -- requirements
Module: trng_arb_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 511, meaning max cycles in RUN before abort.
REQ-002 SHALL have parameter RETRY_MAX, default 3, meaning max health-check retries per grant.
REQ-003 clk  input  1  clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  per-requester request, level, held until rack or abandoned.
REQ-006 gnt  output  4  one-hot grant to current owner; 0 when idle.
REQ-007 rdata  output  128  random word delivered to owner.
REQ-008 rvalid  output  1  rdata valid; held until rack.
REQ-009 rack  input  1  owner accepts rdata; sampled only while rvalid=1.
REQ-010 trng_rst  output  1  one-cycle restart pulse to TRNG core.
REQ-011 trng_en  output  1  TRNG enable, high only in RUN.
REQ-012 trng_data  input  128  TRNG output word.
REQ-013 trng_done  input  1  TRNG completion flag (level).
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 err  output  1  one-cycle pulse on timeout or retry exhaustion.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, RUN, CHECK, DELIVER.
REQ-017 IDLE: if req!=0, SHALL register one-hot gnt to round-robin winner (search from ptr upward, wrap 3->0) and go to CLEAR next cycle; req=0 stays IDLE.
REQ-018 CLEAR: trng_rst=1 for exactly one cycle, retry counter unchanged, cycle counter cleared, then RUN.
REQ-019 RUN: trng_en=1, 9-bit cycle counter increments each cycle; trng_done=1 SHALL latch trng_data into rdata and go to CHECK; trng_done takes priority over timeout in the same cycle.
REQ-020 RUN: counter==TIMEOUT without trng_done SHALL pulse err, clear gnt, go IDLE; ptr advances past owner.
REQ-021 CHECK: one cycle; pass -> DELIVER; fail -> increment retry counter and go CLEAR; fail with retry counter==RETRY_MAX SHALL pulse err, clear gnt, go IDLE.
REQ-022 DELIVER: rvalid=1, rdata stable; rack=1 SHALL clear rvalid and gnt the same edge, set ptr=owner+1 mod 4, go IDLE.
REQ-023 Owner deasserting its req in CLEAR/RUN/CHECK/DELIVER SHALL abort to IDLE next edge: gnt=0, rvalid=0, trng_en=0, no err, ptr advances.
REQ-024 Changes of non-owner req bits SHALL NOT affect the current transaction.
REQ-025 rack while rvalid=0 SHALL be ignored.
REQ-026 Retry counter SHALL clear on every new grant.
REQ-027 Grant-to-rvalid latency SHALL be 3 + N cycles on first-pass success, N = cycles from trng_en rise to trng_done.

Reset
REQ-028 rst SHALL force IDLE, gnt=0, rdata=0, rvalid=0, trng_rst=1 (reset cycle only), trng_en=0, busy=0, err=0, ptr=0, counters=0.
REQ-029 rst mid-transaction SHALL discard the transaction with no err pulse.

Configuration
REQ-030 Macro TRNG_ARB_HEALTH_CHECK_EN defined: CHECK SHALL fail on rdata all-zero, all-ones, or equal to last delivered word (128-bit history register, reset 0).
REQ-031 Macro undefined: CHECK SHALL always pass, history register SHALL be absent, retry path unreachable.

Verification
REQ-032 req=4'b0010, trng_done after 201 RUN cycles, data 128'h3dd16a0a3554db070e0b00ce143b7344 -> gnt=4'b0010, rvalid with that rdata 204 cycles after grant; rack -> gnt=0.
REQ-033 req=4'b1111 held, four transactions acked -> grant order 0001,0010,0100,1000, then 0001.
REQ-034 trng_done never asserted -> err pulse at RUN count 511, gnt=0, state IDLE.
REQ-035 Health macro on, trng_data=0 each time -> three CLEAR retries (3 trng_rst pulses after first), then err, no rvalid; macro off -> rvalid with rdata=0.
REQ-036 Owner drops req in RUN -> next edge gnt=0, trng_en=0, no err; rst asserted in DELIVER -> rvalid=0, rdata=0 next edge.
